id_ex_stage: RTL

//  ID->EX pipeline register for the logic/ALU path. Selects forwarded operands,

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fwd_mux.sv | 27 ++
 rtl/id_ex_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, logic-op codes and the
// ID->EX pipeline bundle.
package cpu_pkg;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_AND = 4'h0;
  localparam logic [OPW-1:0] OP_OR  = 4'h1;
  localparam logic [OPW-1:0] OP_XOR = 4'h4;
  localparam logic [OPW-1:0] OP_NOR = 4'h5;

  localparam logic [RW-1:0] REG0 = '0;

  typedef struct packed {
    logic           valid;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
    logic [DW-1:0]  sd;
    logic [RW-1:0]  rd;
    logic           we;
    logic           mr;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register.
// EX/MEM beats MEM/WB; register 0 always reads the register file.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] rf_data,
  input  logic          exm_we,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_we,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic [DW-1:0] data
);

  always_comb begin
    data = rf_data;
    if (src != REG0) begin
      if (exm_we && exm_rd == src)
        data = exm_data;
      else if (mwb_we && mwb_rd == src)
        data = mwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX register for the logic/ALU path with forwarding,
// load-use hazard detection and stall/flush/bubble control.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  input  logic           id_valid,
  input  logic [RW-1:0]  id_rs_addr,
  input  logic [RW-1:0]  id_rt_addr,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [DW-1:0]  id_imm,
  input  logic           id_use_imm,
  input  logic [OPW-1:0] id_op,
  input  logic [RW-1:0]  id_rd_addr,
  input  logic           id_reg_we,
  input  logic           id_mem_read,
  input  logic           exm_we,
  input  logic [RW-1:0]  exm_rd,
  input  logic [DW-1:0]  exm_data,
  input  logic           mwb_we,
  input  logic [RW-1:0]  mwb_rd,
  input  logic [DW-1:0]  mwb_data,
  output logic           ex_valid,
  output logic [DW-1:0]  ex_a,
  output logic [DW-1:0]  ex_b,
  output logic [OPW-1:0] ex_op,
  output logic [DW-1:0]  ex_store_data,
  output logic [RW-1:0]  ex_rd_addr,
  output logic           ex_reg_we,
  output logic           ex_mem_read,
  output logic           hazard_stall
);

  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  id_ex_t        nxt;
  id_ex_t        q;

  fwd_mux u_rs_fwd (
    .src      (id_rs_addr),
    .rf_data  (id_rs_data),
    .exm_we   (exm_we),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .mwb_we   (mwb_we),
    .mwb_rd   (mwb_rd),
    .mwb_data (mwb_data),
    .data     (rs_fwd)
  );

  fwd_mux u_rt_fwd (
    .src      (id_rt_addr),
    .rf_data  (id_rt_data),
    .exm_we   (exm_we),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .mwb_we   (mwb_we),
    .mwb_rd   (mwb_rd),
    .mwb_data (mwb_data),
    .data     (rt_fwd)
  );

  // ex_mem_read is already qualified by ex_valid
  assign hazard_stall = ex_mem_read
                     && (ex_rd_addr != REG0)
                     && id_valid
                     && ((ex_rd_addr == id_rs_addr)
                      || (!id_use_imm
                       && ex_rd_addr == id_rt_addr));

  always_comb begin
    nxt       = '0;
    nxt.valid = id_valid;
    nxt.a     = rs_fwd;
    nxt.b     = id_use_imm ? id_imm : rt_fwd;
    nxt.op    = id_op;
    nxt.sd    = rt_fwd;
    nxt.rd    = id_rd_addr;
    nxt.we    = id_reg_we && id_valid;
    nxt.mr    = id_mem_read && id_valid;
  end

  // A bubble is all-zero so the logic unit sees AND of zeros
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (flush)
      q <= '0;
    else if (stall)
      q <= q;
    else if (hazard_stall)
      q <= '0;
    else
      q <= nxt;
  end

  assign ex_valid      = q.valid;
  assign ex_a          = q.a;
  assign ex_b          = q.b;
  assign ex_op         = q.op;
  assign ex_store_data = q.sd;
  assign ex_rd_addr    = q.rd;
  assign ex_reg_we     = q.we;
  assign ex_mem_read   = q.mr;

endmodule
